// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder (format codes, opcodes, field bundle).
// The IMM_RANGE_CHECK_EN build option uses imm_out_of_range() from here.
package instr_encoder_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_SEL   = $clog2(NUM_REGS);
    localparam int unsigned ADDR_SIZE = 10;
    localparam int unsigned LEN_SIZE  = ADDR_SIZE + 1;
    localparam int unsigned FMT_SIZE  = 3;
    localparam int unsigned OPC_SIZE  = 7;
    localparam int unsigned F3_SIZE   = 3;
    localparam int unsigned F7_SIZE   = 7;

    // Instruction format selector codes (shared with the decoder)
    localparam logic [FMT_SIZE-1:0] FMT_R = 3'd0;
    localparam logic [FMT_SIZE-1:0] FMT_I = 3'd1;
    localparam logic [FMT_SIZE-1:0] FMT_S = 3'd2;
    localparam logic [FMT_SIZE-1:0] FMT_B = 3'd3;
    localparam logic [FMT_SIZE-1:0] FMT_U = 3'd4;
    localparam logic [FMT_SIZE-1:0] FMT_J = 3'd5;

    // RV32I base opcodes
    localparam logic [OPC_SIZE-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPC_SIZE-1:0] OPC_AUIPC  = 7'h17;
    localparam logic [OPC_SIZE-1:0] OPC_JAL    = 7'h6f;
    localparam logic [OPC_SIZE-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPC_SIZE-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_SIZE-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPC_SIZE-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_SIZE-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OPC_SIZE-1:0] OPC_OP     = 7'h33;

    // addi x0,x0,0
    localparam logic [WORD_SIZE-1:0] NOP_WORD = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    typedef struct packed {
        logic [FMT_SIZE-1:0]  fmt;
        logic [OPC_SIZE-1:0]  opcode;
        logic [F3_SIZE-1:0]   funct3;
        logic [F7_SIZE-1:0]   funct7;
        logic [REG_SEL-1:0]   rd;
        logic [REG_SEL-1:0]   rs1;
        logic [REG_SEL-1:0]   rs2;
        logic [WORD_SIZE-1:0] imm;
    } instr_fields_t;

    // True when the immediate cannot be represented exactly in the format's field bits
    function automatic logic imm_out_of_range(input instr_fields_t f);
        logic bad;
        bad = 1'b0;
        case (f.fmt)
            FMT_I, FMT_S: bad = !((&f.imm[31:11]) || (~|f.imm[31:11]));
            FMT_B:        bad = !((&f.imm[31:12]) || (~|f.imm[31:12])) || f.imm[0];
            FMT_J:        bad = !((&f.imm[31:20]) || (~|f.imm[31:20])) || f.imm[0];
            FMT_U:        bad = |f.imm[11:0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer: turns a field bundle into one 32-bit instruction word.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  instr_fields_t          i_fields,
    output logic [WORD_SIZE-1:0]   o_word
);

    // Select the bit layout for the requested format; unknown formats become a nop
    always_comb begin
        o_word = NOP_WORD;
        case (i_fields.fmt)
            FMT_R: o_word = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                             i_fields.funct3, i_fields.rd, i_fields.opcode};
            FMT_I: begin
                if (i_fields.funct3 == 3'b001 || i_fields.funct3 == 3'b101) begin
                    o_word = {i_fields.funct7, i_fields.imm[4:0], i_fields.rs1,
                              i_fields.funct3, i_fields.rd, i_fields.opcode};
                end else begin
                    o_word = {i_fields.imm[11:0], i_fields.rs1,
                              i_fields.funct3, i_fields.rd, i_fields.opcode};
                end
            end
            FMT_S: o_word = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                             i_fields.funct3, i_fields.imm[4:0], i_fields.opcode};
            FMT_B: o_word = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2,
                             i_fields.rs1, i_fields.funct3, i_fields.imm[4:1],
                             i_fields.imm[11], i_fields.opcode};
            FMT_U: o_word = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
            FMT_J: o_word = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                             i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
            default: o_word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts RV32I field bundles and streams packed words into imem
// at incrementing addresses under a start/busy/done job FSM.
// Build option IMM_RANGE_CHECK_EN: out-of-range immediates are dropped and flagged in err[1].
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    input  logic [ADDR_SIZE:0]    job_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FMT_SIZE-1:0]   fmt,
    input  logic [OPC_SIZE-1:0]   opcode,
    input  logic [F3_SIZE-1:0]    funct3,
    input  logic [F7_SIZE-1:0]    funct7,
    input  logic [REG_SEL-1:0]    rd,
    input  logic [REG_SEL-1:0]    rs1,
    input  logic [REG_SEL-1:0]    rs2,
    input  logic [WORD_SIZE-1:0]  imm,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [ADDR_SIZE-1:0]  wr_addr,
    output logic [WORD_SIZE-1:0]  wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err
);

    enc_state_t             r_state;
    enc_state_t             w_state_nxt;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [LEN_SIZE-1:0]    r_remain;
    logic                   r_wr_en;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [WORD_SIZE-1:0]   r_wr_data;
    logic                   r_busy;
    logic                   r_done;
    logic [1:0]             r_err;

    instr_fields_t          w_fields;
    logic [WORD_SIZE-1:0]   w_word;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_fire;
    logic                   w_wrap;
    logic                   w_drop;
    logic                   w_in_ready;

    // Gather the input fields into one bundle for the packer
    always_comb begin
        w_fields        = '0;
        w_fields.fmt    = fmt;
        w_fields.opcode = opcode;
        w_fields.funct3 = funct3;
        w_fields.funct7 = funct7;
        w_fields.rd     = rd;
        w_fields.rs1    = rs1;
        w_fields.rs2    = rs2;
        w_fields.imm    = imm;
    end

    instr_pack u_pack (
        .i_fields (w_fields),
        .o_word   (w_word)
    );

`ifdef IMM_RANGE_CHECK_EN
    assign w_drop = imm_out_of_range(w_fields);
`else
    assign w_drop = 1'b0;
`endif

    // Handshake qualifiers; a stalled write blocks new bundles so its data stays put
    assign w_in_ready = (r_state == ST_RUN) && (r_remain != '0) && (!r_wr_en || wr_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_fire     = r_wr_en && wr_ready;
    assign w_start    = start && (r_state == ST_IDLE);
    assign w_wrap     = w_fire && (&r_wr_addr) && (r_remain != '0);

    // Next-state logic for the job FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (job_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if ((r_remain == '0) && (!r_wr_en || w_fire)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job counters and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_err    <= '0;
        end else if (w_start) begin
            r_addr   <= base_addr;
            r_remain <= job_len;
            r_err    <= '0;
        end else begin
            if (w_fire) begin
                r_addr <= r_addr + ADDR_SIZE'(1);
            end
            if (w_accept) begin
                r_remain <= r_remain - LEN_SIZE'(1);
            end
            if (w_wrap) begin
                r_err[0] <= 1'b1;
            end
            if (w_accept && w_drop) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    // Write stage: holds the packed word until imem takes it; the address skips ahead
    // when the previous write fires in the same cycle a new bundle is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept && !w_drop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_fire ? (r_addr + ADDR_SIZE'(1)) : r_addr;
            r_wr_data <= w_word;
        end else if (w_fire) begin
            r_wr_en   <= 1'b0;
        end
    end

    // Registered status outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign in_ready = w_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, stalls, wrap, reset, imm handling.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_SIZE-1:0]  base_addr;
    logic [ADDR_SIZE:0]    job_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [FMT_SIZE-1:0]   fmt;
    logic [OPC_SIZE-1:0]   opcode;
    logic [F3_SIZE-1:0]    funct3;
    logic [F7_SIZE-1:0]    funct7;
    logic [REG_SEL-1:0]    rd, rs1, rs2;
    logic [WORD_SIZE-1:0]  imm;
    logic                  wr_en;
    logic                  wr_ready;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic                  busy;
    logic                  done;
    logic [1:0]            err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .job_len(job_len),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write that will be taken on the coming rising edge
    always @(negedge clk) begin
        if (rst_n && wr_en && wr_ready) begin
            q_addr.push_back(32'(wr_addr));
            q_data.push_back(wr_data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    // Raise in_valid and hold it until the bundle is accepted (bounded)
    task automatic wait_accept(input string tag);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_accepted"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] len);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = b; job_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done"}, 32'(ok), 32'd1);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic exp_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d);
        if (idx < q_addr.size()) begin
            check_eq({tag, "_addr"}, q_addr[idx], a);
            check_eq({tag, "_data"}, q_data[idx], d);
        end else begin
            check_eq({tag, "_missing"}, 32'(q_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; job_len = '0; in_valid = 1'b0;
        wr_ready = 1'b1;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_wr_en",    32'(wr_en),    32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        check_eq("rst_done",     32'(done),     32'd0);
        check_eq("rst_wr_addr",  32'(wr_addr),  32'd0);
        check_eq("rst_wr_data",  wr_data,       32'd0);
        check_eq("rst_err",      32'(err),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back R/R/I at full rate
        clear_log();
        do_start(10'd0, 11'd3);
        check_eq("t1_busy", 32'(busy), 32'd1);
        set_fields(FMT_R, OPC_OP, 3'd0, 7'h00, 5'd24, 5'd29, 5'd14, 32'd0);
        wait_accept("t1_add");
        set_fields(FMT_R, OPC_OP, 3'd5, 7'h20, 5'd12, 5'd23, 5'd0, 32'd0);
        wait_accept("t1_sra");
        set_fields(FMT_I, OPC_LOAD, 3'd2, 7'h00, 5'd18, 5'd28, 5'd0, 32'd292);
        wait_accept("t1_lw");
        wait_done("t1");
        check_eq("t1_count", 32'(q_addr.size()), 32'd3);
        exp_write("t1_w0", 0, 32'h000, 32'h00ee8c33);
        exp_write("t1_w1", 1, 32'h001, 32'h400bd633);
        exp_write("t1_w2", 2, 32'h002, 32'h124e2903);
        if (q_cyc.size() == 3) begin
            check_eq("t1_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
            check_eq("t1_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd1);
        end

        // Stalled imem: first word held, no acceptance until write drains
        clear_log();
        do_start(10'd20, 11'd2);
        wr_ready = 1'b0;
        set_fields(FMT_S, OPC_STORE, 3'd1, 7'h00, 5'd0, 5'd6, 5'd17, 32'd460);
        wait_accept("t2_sh");
        set_fields(FMT_B, OPC_BRANCH, 3'd5, 7'h00, 5'd0, 5'd6, 5'd19, 32'd724);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t2_hold_en",    32'(wr_en),    32'd1);
            check_eq("t2_hold_data",  wr_data,       32'h1d131623);
            check_eq("t2_hold_addr",  32'(wr_addr),  32'd20);
            check_eq("t2_hold_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        wait_accept("t2_bge");
        wait_done("t2");
        check_eq("t2_count", 32'(q_addr.size()), 32'd2);
        exp_write("t2_w0", 0, 32'd20, 32'h1d131623);
        exp_write("t2_w1", 1, 32'd21, 32'h2d335a63);

        // Address wrap from all-ones to zero
        clear_log();
        do_start(10'h3ff, 11'd2);
        set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hffffffff);
        wait_accept("t3_addi");
        set_fields(FMT_U, OPC_LUI, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
        wait_accept("t3_lui");
        wait_done("t3");
        exp_write("t3_w0", 0, 32'h3ff, 32'hfff00093);
        exp_write("t3_w1", 1, 32'h000, 32'h123452b7);
        check_eq("t3_err", 32'(err), 32'd1);

        // J format and undefined format; err cleared by the new start
        clear_log();
        do_start(10'd5, 11'd2);
        set_fields(FMT_J, OPC_JAL, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        wait_accept("t3b_jal");
        set_fields(3'd7, 7'h7f, 3'd7, 7'h7f, 5'd31, 5'd31, 5'd31, 32'hffffffff);
        wait_accept("t3b_bad_fmt");
        wait_done("t3b");
        exp_write("t3b_w0", 0, 32'd5, 32'h001000ef);
        exp_write("t3b_w1", 1, 32'd6, 32'h00000013);
        check_eq("t3b_err", 32'(err), 32'd0);

        // Zero-length job
        clear_log();
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 10'd9; job_len = 11'd0;
        @(negedge clk);
        check_eq("t4_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("t4_done",   32'(done),  32'd1);
        check_eq("t4_wr_en",  32'(wr_en), 32'd0);
        @(negedge clk);
        check_eq("t4_done_off", 32'(done), 32'd0);
        check_eq("t4_busy_off", 32'(busy), 32'd0);
        check_eq("t4_count",  32'(q_addr.size()), 32'd0);

        // Reset while a write is pending, then a fresh job
        clear_log();
        do_start(10'd8, 11'd1);
        wr_ready = 1'b0;
        set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
        wait_accept("t5_addi");
        check_eq("t5_pending", 32'(wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_wr_en", 32'(wr_en),    32'd0);
        check_eq("t5_rst_busy",  32'(busy),     32'd0);
        check_eq("t5_rst_ready", 32'(in_ready), 32'd0);
        check_eq("t5_rst_data",  wr_data,       32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        check_eq("t5_dropped", 32'(q_addr.size()), 32'd0);
        do_start(10'd4, 11'd1);
        set_fields(FMT_R, OPC_OP, 3'd0, 7'h00, 5'd24, 5'd29, 5'd14, 32'd0);
        wait_accept("t5_add");
        wait_done("t5");
        check_eq("t5_count", 32'(q_addr.size()), 32'd1);
        exp_write("t5_w0", 0, 32'd4, 32'h00ee8c33);

        // Odd branch offset
        clear_log();
        do_start(10'h40, 11'd1);
        set_fields(FMT_B, OPC_BRANCH, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
        wait_accept("t6_beq");
        wait_done("t6");
`ifdef IMM_RANGE_CHECK_EN
        check_eq("t6_count", 32'(q_addr.size()), 32'd0);
        check_eq("t6_err",   32'(err),           32'd2);
`else
        check_eq("t6_count", 32'(q_addr.size()), 32'd1);
        exp_write("t6_w0", 0, 32'h40, 32'h00208163);
        check_eq("t6_err",   32'(err),           32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
